// File: rtl/instr_cache_dm_pkg.sv
// instr_cache_dm_pkg: shared fetch-state encoding and instruction-word constants
package instr_cache_dm_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD} fetch_state_e;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'd0;
endpackage

// File: rtl/instr_cache_dm_line_ram.sv
// instr_cache_dm_line_ram: LINES x (valid+tag+data) storage, async read, one write port, whole-array invalidate
// Ports: clk, reset (async active-low), rd_idx -> rd_valid/rd_tag/rd_data,
//        we/wr_idx/wr_tag/wr_data write one line, flush_all clears every valid bit (wins over we).
module instr_cache_dm_line_ram #(
    parameter int LINES  = 64,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush_all
);
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            valid_q <= '0;
        else if (flush_all)
            valid_q <= '0;
        else if (we)
            valid_q[wr_idx] <= 1'b1;
    end

    // tag/data need no reset: a line is only ever read through its valid bit
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/instr_cache_dm.sv
// instr_cache_dm: direct-mapped one-word-line instruction cache between CPU fetch and a word-addressed bus
// Ports: clk, reset (async active-low); CPU side addr -> hit/q with clear/hold/flush controls;
//        bus side bus_addr/bus_data/bus_we/bus_start out, bus_q/bus_done in; hit_cnt/miss_cnt statistics.
module instr_cache_dm
    import instr_cache_dm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = INSTR_W,
    parameter int LINES  = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DATA_W-1:0] q,
    input  logic              clear,
    input  logic              hold,
    input  logic              flush,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_we,
    output logic              bus_start,
    input  logic [DATA_W-1:0] bus_q,
    input  logic              bus_done,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] miss_addr_q;
    logic              bus_start_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;
    logic              rd_valid, lookup_hit, fill, fwd, start_miss;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;

    instr_cache_dm_line_ram #(
        .LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (addr[IDX_W-1:0]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .we        (fill),
        .wr_idx    (miss_addr_q[IDX_W-1:0]),
        .wr_tag    (miss_addr_q[ADDR_W-1:IDX_W]),
        .wr_data   (bus_q),
        .flush_all (flush)
    );

    assign lookup_hit = rd_valid && rd_tag == addr[ADDR_W-1:IDX_W];
    assign fill       = state_q == S_FETCH && bus_done && !clear && !flush;
    // the returning word is handed straight to the CPU if it is still asking for it
    assign fwd        = fill && addr == miss_addr_q;
    assign start_miss = state_q == S_IDLE && !lookup_hit && !hold && !clear && !flush;
    assign hit        = !flush && ((state_q == S_IDLE && lookup_hit) || fwd);
    assign q          = hit ? (fwd ? bus_q : rd_data) : DATA_W'(NOP);
    assign bus_addr   = miss_addr_q;
    assign bus_data   = '0;
    assign bus_we     = 1'b0;
    assign bus_start  = bus_start_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            miss_addr_q <= '0;
            bus_start_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_q + CNT_W'(hit);
            case (state_q)
                S_IDLE:
                    if (start_miss) begin
                        state_q     <= S_FETCH;
                        miss_addr_q <= addr;
                        miss_cnt_q  <= miss_cnt_q + CNT_W'(1);
                        bus_start_q <= 1'b1;
                    end
                // an abandoned request still has to run to bus_done before the bus is free
                S_FETCH, S_DISCARD:
                    if (bus_done) begin
                        state_q     <= S_IDLE;
                        bus_start_q <= 1'b0;
                    end else if (clear || flush) begin
                        state_q <= S_DISCARD;
                    end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_cache_dm.sv
// tb_instr_cache_dm: scoreboard bench with a behavioural cache/bus model for instr_cache_dm
module tb_instr_cache_dm;
    localparam int LINES = 64;

    typedef struct packed {
        logic        hit;
        logic [31:0] q;
        logic        bs;
        logic [31:0] ba;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        clear = 1'b0, hold = 1'b0, flush = 1'b0;
    logic [31:0] bus_q = '0;
    logic        bus_done = 1'b0;
    logic        hit, bus_we, bus_start;
    logic [31:0] q, bus_addr, bus_data, hit_cnt, miss_cnt;

    instr_cache_dm dut (
        .clk(clk), .reset(reset), .addr(addr), .hit(hit), .q(q),
        .clear(clear), .hold(hold), .flush(flush),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we), .bus_start(bus_start),
        .bus_q(bus_q), .bus_done(bus_done), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp = 0, n_err = 0;

    // model: which word address each line holds, one outstanding bus request
    logic        lv [LINES];
    logic [31:0] la [LINES];
    logic        busy = 1'b0, drop = 1'b0;
    logic [31:0] maddr = '0, hits = '0, misses = '0;
    int          wcnt = 0, next_wait = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h100 ? 32'hDEADBEEF : a * 32'h9E3779B1 + 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) lv[i] = 1'b0;
        busy = 1'b0; drop = 1'b0; maddr = '0; hits = '0; misses = '0;
    endtask

    // called at posedge+2 with CPU inputs set; drives the bus, predicts this cycle, advances one clock
    task automatic cycle();
        exp_t e;
        int   idx;
        logic cached, ok;
        e = '0;
        if (!reset) begin
            model_reset();
            bus_done = 1'b0;
            bus_q = '0;
        end else begin
            bus_done = busy && wcnt == 0;
            bus_q = bus_done ? mem(maddr) : $urandom();
            idx = int'(addr % LINES);
            cached = lv[idx] && la[idx] == addr;
            ok = busy && bus_done && !drop && !clear && !flush;
            e.hit = busy ? (ok && addr == maddr) : (cached && !flush);
            e.q = e.hit ? mem(addr) : 32'd0;
            e.bs = busy; e.ba = maddr; e.hc = hits; e.mc = misses;
            hits = hits + 32'(e.hit);
            if (flush) for (int i = 0; i < LINES; i++) lv[i] = 1'b0;
            if (busy) begin
                if (bus_done) begin
                    if (ok) begin lv[maddr % LINES] = 1'b1; la[maddr % LINES] = maddr; end
                    busy = 1'b0; drop = 1'b0;
                end else begin
                    wcnt--;
                    if (clear || flush) drop = 1'b1;
                end
            end else if (!cached && !hold && !clear && !flush) begin
                busy = 1'b1; maddr = addr; misses++; wcnt = next_wait;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("hit", 32'(hit), 32'(e.hit));
                check("q", q, e.q);
                check("bus_start", 32'(bus_start), 32'(e.bs));
                check("bus_addr", bus_addr, e.ba);
                check("hit_cnt", hit_cnt, e.hc);
                check("miss_cnt", miss_cnt, e.mc);
                check("bus_we", 32'(bus_we), 32'd0);
                check("bus_data", bus_data, 32'd0);
            end
        end
    end

    task automatic run(input logic [31:0] a, input int n);
        addr = a;
        repeat (n) cycle();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #2;
        repeat (2) cycle();
        reset = 1'b1;
        next_wait = 2;
        run(32'h100, 6);
        next_wait = 1;
        run(32'h140, 5);
        run(32'h100, 5);
        next_wait = 3;
        run(32'h200, 2);
        clear = 1'b1; cycle(); clear = 1'b0;
        repeat (6) cycle();
        next_wait = 0;
        for (int i = 0; i < 4; i++) run(32'h10 + 32'(i), 3);
        flush = 1'b1; cycle(); flush = 1'b0;
        for (int i = 0; i < 4; i++) run(32'h10 + 32'(i), 3);
        next_wait = 1;
        run(32'h300, 2);
        flush = 1'b1; cycle(); flush = 1'b0;
        repeat (4) cycle();
        hold = 1'b1; run(32'h400, 4); hold = 1'b0;
        repeat (4) cycle();
        next_wait = 5;
        run(32'h500, 2);
        reset = 1'b0; cycle(); cycle(); reset = 1'b1;
        repeat (8) cycle();
        for (int k = 0; k < 3000; k++) begin
            addr = $urandom_range(0, 9) == 0 ? $urandom() : 32'($urandom_range(0, 3) * 64 + $urandom_range(0, 5));
            clear = $urandom_range(0, 11) == 0;
            hold = $urandom_range(0, 7) == 0;
            flush = $urandom_range(0, 39) == 0;
            next_wait = $urandom_range(0, 4);
            reset = $urandom_range(0, 499) != 0;
            cycle();
        end
        reset = 1'b1; clear = 1'b0; hold = 1'b0; flush = 1'b0;
        repeat (8) cycle();
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
